// File: rtl/vx_ibuf_arb_pkg.sv
// VX_gpu_pkg: shared types and constants for the instruction buffer.
//   NUM_WARPS_DEF - default warp count
//   NW_WIDTH      - warp-id width derived from the default warp count
//   DATAW         - width of the packed decode data word (uuid .. is_mstore)
//   wid_t         - warp-id type
//   decode_data_t - packed decode data word
//   arb_state_e   - issue arbiter state (free-running scan / locked selection)
package VX_gpu_pkg;

  localparam int unsigned NUM_WARPS_DEF = 4;
  localparam int unsigned NW_WIDTH      = (NUM_WARPS_DEF > 1) ? $clog2(NUM_WARPS_DEF) : 1;
  localparam int unsigned DATAW         = 128;

  typedef logic [NW_WIDTH-1:0] wid_t;
  typedef logic [DATAW-1:0]    decode_data_t;

  typedef enum logic {
    ARB_FREE,
    ARB_LOCKED
  } arb_state_e;

endpackage

// File: rtl/vx_ibuf_arb_fifo.sv
// vx_ibuf_fifo: one per-warp instruction queue.
//   clk, reset_n - clock, asynchronous active-low reset (control state only)
//   push, din    - enqueue din at the tail (ignored when full)
//   pop          - dequeue the head (ignored when empty)
//   dout         - head entry, read combinationally from storage
//   full, empty  - occupancy flags
module vx_ibuf_fifo
  import VX_gpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DATAW = 128
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] din,
  output logic [DATAW-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DATAW-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    // Explicit wrap so non-power-of-two depths stay in range.
    if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/vx_ibuf_arb.sv
// vx_ibuf_arb: per-warp instruction buffer with round-robin issue select.
//   clk, reset_n          - clock, asynchronous active-low reset
//   dec_valid/data/wid    - decode packet in; dec_ready = target queue not full
//   ibuf_pop              - one-hot pulse per dequeued warp entry
//   iss_valid/data/wid    - packet offered to issue; iss_ready accepts it
module vx_ibuf_arb
  import VX_gpu_pkg::*;
#(
  parameter int unsigned NUM_WARPS = 4,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned DATAW     = VX_gpu_pkg::DATAW
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         dec_valid,
  input  logic [DATAW-1:0]             dec_data,
  input  logic [$clog2(NUM_WARPS)-1:0] dec_wid,
  output logic                         dec_ready,
  output logic [NUM_WARPS-1:0]         ibuf_pop,
  output logic                         iss_valid,
  output logic [DATAW-1:0]             iss_data,
  output logic [$clog2(NUM_WARPS)-1:0] iss_wid,
  input  logic                         iss_ready
);

  localparam int unsigned WW = $clog2(NUM_WARPS);

  logic [NUM_WARPS-1:0] full, empty, push;
  logic [DATAW-1:0]     dout [NUM_WARPS];
  arb_state_e           state_q, state_d;
  logic [WW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [WW-1:0]        lock_wid_q, lock_wid_d;
  logic [WW-1:0]        sel_wid;
  logic                 do_pop;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_fifo
    vx_ibuf_fifo #(
      .DEPTH (DEPTH),
      .DATAW (DATAW)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push[w]),
      .pop     (ibuf_pop[w]),
      .din     (dec_data),
      .dout    (dout[w]),
      .full    (full[w]),
      .empty   (empty[w])
    );
  end

  assign dec_ready = !full[dec_wid];
  assign iss_valid = (~empty != '0);
  assign do_pop    = iss_valid && iss_ready;
  assign iss_wid   = sel_wid;
  assign iss_data  = dout[sel_wid];

  always_comb begin
    push = '0;
    if (dec_valid && dec_ready) push[dec_wid] = 1'b1;
  end

  // First non-empty warp at or above rr_ptr (circular); a held selection wins.
  always_comb begin
    logic found;
    found   = 1'b0;
    sel_wid = rr_ptr_q;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      logic [WW-1:0] idx;
      idx = WW'((32'(rr_ptr_q) + i) % NUM_WARPS);
      if (!found && !empty[idx]) begin
        sel_wid = idx;
        found   = 1'b1;
      end
    end
    if (state_q == ARB_LOCKED) sel_wid = lock_wid_q;
  end

  always_comb begin
    ibuf_pop = '0;
    if (do_pop) ibuf_pop[sel_wid] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_wid_d = lock_wid_q;
    if (iss_valid) begin
      if (iss_ready) begin
        state_d  = ARB_FREE;
        rr_ptr_d = (sel_wid == WW'(NUM_WARPS - 1)) ? '0 : sel_wid + 1'b1;
      end else begin
        state_d    = ARB_LOCKED;
        lock_wid_d = sel_wid;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB_FREE;
      rr_ptr_q   <= '0;
      lock_wid_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_wid_q <= lock_wid_d;
    end
  end

endmodule
